// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order retirement reorder buffer with SS-wide dispatch/commit
// Optional flush port and logic are enabled by defining ROB_FLUSH_EN.
module reorder_buffer #(
  parameter int SS        = 2,
  parameter int DEPTH     = 16,
  parameter int WB        = 2,
  parameter int PAYLOAD_W = 32,
  localparam int IW       = $clog2(DEPTH),
  localparam int PW       = IW + 1
) (
  input  logic                          clk,
  input  logic                          rst,
`ifdef ROB_FLUSH_EN
  input  logic                          flush,
`endif
  input  logic [SS-1:0]                 dispatch_mask,
  input  logic [SS-1:0][PAYLOAD_W-1:0]  dispatch_payload,
  output logic                          dispatch_ready,
  output logic [SS-1:0][IW-1:0]         dispatch_rob_id,
  input  logic [WB-1:0]                 wb_valid,
  input  logic [WB-1:0][IW-1:0]         wb_rob_id,
  output logic [SS-1:0]                 commit_valid,
  output logic [SS-1:0][PAYLOAD_W-1:0]  commit_payload,
  output logic [SS-1:0][63:0]           commit_order,
  output logic [PW-1:0]                 occupancy
);

  logic [PW-1:0]        head, tail;
  logic [DEPTH-1:0]     valid, done;
  logic [PAYLOAD_W-1:0] mem [DEPTH];
  logic [63:0]          order_counter;
  logic                 flush_now;
  logic                 dispatch_fire;
  logic                 run;
  logic [PW-1:0]        disp_cnt, com_cnt;
  logic [SS-1:0][IW-1:0] commit_idx;

`ifdef ROB_FLUSH_EN
  assign flush_now = flush;
`else
  assign flush_now = 1'b0;
`endif

  assign occupancy      = tail - head;
  // Readiness uses pre-edge occupancy only; same-cycle commits do not count.
  assign dispatch_ready = (occupancy <= PW'(DEPTH - SS));
  assign dispatch_fire  = dispatch_ready && (dispatch_mask != '0) && !flush_now;

  for (genvar g = 0; g < SS; g++) begin : g_lane
    assign dispatch_rob_id[g] = tail[IW-1:0] + IW'(g);
    assign commit_idx[g]      = head[IW-1:0] + IW'(g);
  end

  always_comb begin
    disp_cnt = '0;
    for (int i = 0; i < SS; i++) disp_cnt = disp_cnt + PW'(dispatch_mask[i]);
  end

  // Longest valid&done prefix from head, capped at SS lanes.
  always_comb begin
    run            = !flush_now;
    com_cnt        = '0;
    commit_valid   = '0;
    commit_payload = '0;
    commit_order   = '0;
    for (int i = 0; i < SS; i++) begin
      run = run && valid[commit_idx[i]] && done[commit_idx[i]];
      if (run) begin
        commit_valid[i]   = 1'b1;
        commit_payload[i] = mem[commit_idx[i]];
        commit_order[i]   = order_counter + 64'(i);
        com_cnt           = com_cnt + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head          <= '0;
      tail          <= '0;
      order_counter <= '0;
      valid         <= '0;
      done          <= '0;
    end else if (flush_now) begin
      valid <= '0;
      done  <= '0;
      tail  <= head;
    end else begin
      for (int p = 0; p < WB; p++)
        if (wb_valid[p] && valid[wb_rob_id[p]]) done[wb_rob_id[p]] <= 1'b1;
      for (int i = 0; i < SS; i++)
        if (commit_valid[i]) valid[commit_idx[i]] <= 1'b0;
      if (dispatch_fire) begin
        for (int i = 0; i < SS; i++)
          if (dispatch_mask[i]) begin
            valid[dispatch_rob_id[i]] <= 1'b1;
            done[dispatch_rob_id[i]]  <= 1'b0;
          end
        tail <= tail + disp_cnt;
      end
      head          <= head + com_cnt;
      order_counter <= order_counter + 64'(com_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (dispatch_fire)
      for (int i = 0; i < SS; i++)
        if (dispatch_mask[i]) mem[dispatch_rob_id[i]] <= dispatch_payload[i];
  end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter SS, default 2: dispatch and commit lanes per cycle, legal range 1..4.
REQ-002 SHALL have parameter DEPTH, default 16: entry count, power of two, at least 2*SS.
REQ-003 SHALL have parameter WB, default 2: writeback (CDB) ports.
REQ-004 SHALL have parameter PAYLOAD_W, default 32: opaque per-entry payload width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port dispatch_mask, input, SS bits: lanes presenting an instruction; set bits SHALL be contiguous from lane 0.
REQ-008 SHALL have port dispatch_payload, input, SS x PAYLOAD_W: payload for each lane.
REQ-009 SHALL have port dispatch_ready, output, 1 bit: high when free entries >= SS.
REQ-010 SHALL have port dispatch_rob_id, output, SS x log2(DEPTH): entry index assigned to each lane, equal to tail+i.
REQ-011 SHALL have port wb_valid, input, WB bits: writeback strobe per port.
REQ-012 SHALL have port wb_rob_id, input, WB x log2(DEPTH): entry completed by each port.
REQ-013 SHALL have port commit_valid, output, SS bits: lanes retiring this cycle, contiguous from lane 0.
REQ-014 SHALL have port commit_payload, output, SS x PAYLOAD_W: payload of the entry at head+i.
REQ-015 SHALL have port commit_order, output, SS x 64: retirement sequence number of each lane.
REQ-016 SHALL have port occupancy, output, log2(DEPTH)+1 bits: number of valid entries.
REQ-017 SHALL have port flush, input, 1 bit: present only when ROB_FLUSH_EN is defined.

Function
REQ-018 SHALL keep head and tail pointers of log2(DEPTH)+1 bits each; the extra MSB is the wrap bit. Empty when head==tail. Full when indices match and wrap bits differ.
REQ-019 SHALL accept dispatch only when dispatch_ready=1 and dispatch_mask!=0. It SHALL write valid=1, done=0 and the payload into entries tail..tail+popcount-1, then advance tail by popcount. Dispatch while not ready SHALL be ignored.
REQ-020 SHALL set done=1 on each valid entry named by an asserted wb_valid at the clock edge. Writeback to an invalid entry SHALL be ignored. Duplicate IDs across ports SHALL be harmless.
REQ-021 SHALL drive commit_valid[i]=1 combinationally for the longest in-order prefix of valid, done entries starting at head, capped at SS. A lane behind a not-done entry SHALL NOT commit.
REQ-022 SHALL retire the committed entries on the same edge: clear valid and advance head by the commit count. There is no consumer backpressure.
REQ-023 SHALL assign commit_order[i] = order_counter + i, and advance order_counter by the commit count each cycle.
REQ-024 SHALL compute dispatch_ready from the pre-edge occupancy; same-cycle commits do not free space for same-cycle dispatch.
REQ-025 SHALL allow dispatch, writeback and commit in the same cycle. A writeback to the head entry becomes committable on the following cycle.
REQ-026 SHALL wrap pointer indices modulo DEPTH; dispatch_rob_id and commit lanes SHALL wrap across the boundary correctly.
REQ-027 SHALL drive commit_payload and commit_order as 0 on non-committing lanes.

Reset
REQ-028 SHALL, while rst=1, clear head, tail, order_counter and all valid/done bits. Resulting outputs: dispatch_ready=1, occupancy=0, commit_valid=0, dispatch_rob_id[i]=i.
REQ-029 SHALL discard all in-flight entries when reset is asserted mid-operation, with no commit on that edge.

Configuration
REQ-030 SHALL, with ROB_FLUSH_EN defined, make flush=1 clear all valid/done bits and set tail=head on the edge. During a flush cycle, commit_valid SHALL be 0 and flush SHALL take priority over dispatch and writeback. order_counter SHALL be preserved.
REQ-031 SHALL, without ROB_FLUSH_EN, omit the flush port and flush logic; all other behaviour SHALL be identical.

Verification
REQ-032 SHALL verify: reset, then dispatch mask 2'b11 four times -> IDs 0..7 assigned, occupancy=8, commit_valid=0.
REQ-033 SHALL verify: writeback ID 1 only -> no commit; then writeback ID 0 -> next cycle commit_valid=2'b11 with orders 0 and 1.
REQ-034 SHALL verify: fill DEPTH=16 -> dispatch_ready=0; a dispatch attempted while not ready -> tail unchanged.
REQ-035 SHALL verify wrap-around: head=tail=15, dispatch 2 lanes -> dispatch_rob_id={15,0}; complete both -> both commit in order.
REQ-036 SHALL verify, with ROB_FLUSH_EN: 5 entries with IDs 0..4 outstanding, entries 0..2 done, flush -> commit_valid=0, occupancy=0 next cycle; then commit order continues from its prior value.
REQ-037 SHALL verify: assert rst mid-stream with 6 entries held -> outputs match REQ-028 immediately, without waiting for a clock edge.
